// File: rtl/bus_select_arbiter_if.sv
// Request/grant bundle between the two datapath requesters and the select arbiter.
// Latency: none (wires only).
// Backpressure: level requests are held by the requester until its grant is no longer needed.
interface bus_select_arbiter_if;
  logic ReqA;
  logic ReqB;
  logic GrantA;
  logic GrantB;
  logic Selector;
  logic Busy;
  logic Preempt;

  // Requester side: drives requests, observes grants and the mux select.
  modport master (
    output ReqA, ReqB,
    input  GrantA, GrantB, Selector, Busy, Preempt
  );

  // Arbiter side.
  modport slave (
    input  ReqA, ReqB,
    output GrantA, GrantB, Selector, Busy, Preempt
  );
endinterface

// File: rtl/bus_select_arbiter.sv
// Round-robin owner of the 16-bit operand/address mux select (A = fetch, B = data).
// Latency: one cycle from a sampled request to a visible grant; all outputs registered.
// Backpressure: owner keeps the mux while its request is held, up to MAX_HOLD cycles under contention.
module bus_select_arbiter #(
  parameter int MAX_HOLD = 8,  // 0 = unlimited hold, otherwise 1..15
  parameter int CNT_W    = 4   // 2**CNT_W must exceed MAX_HOLD
) (
  input logic                 CLK,
  input logic                 Reset,
  bus_select_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  // Preemption threshold; only meaningful when MAX_HOLD is non-zero.
  localparam int                HOLD_LIM_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0]  HOLD_LIM   = HOLD_LIM_I[CNT_W-1:0];
  localparam logic              HOLD_EN    = (MAX_HOLD != 0);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             last_owner_q, last_owner_d;
  logic             sel_q, sel_d;
  logic             preempt_q, preempt_d;

  logic [CNT_W-1:0] hold_cnt_inc;
  logic             hold_expired;

  // Saturating increment so an uncontended owner never wraps back below the limit.
  assign hold_cnt_inc = (hold_cnt_q == {CNT_W{1'b1}}) ? hold_cnt_q : hold_cnt_q + 1'b1;
  // A count already past the limit (long uncontended hold) preempts as soon as contention appears.
  assign hold_expired = HOLD_EN && (hold_cnt_q >= HOLD_LIM);

  // Next-state decode: idle arbitration, voluntary release, and forced hand-over.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;
    sel_d        = sel_q;  // select only moves on a grant hand-over
    preempt_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ReqA && (!bus.ReqB || last_owner_q == OWN_B)) begin
          state_d      = GNT_A;
          hold_cnt_d   = '0;
          last_owner_d = OWN_A;
          sel_d        = 1'b0;
        end else if (bus.ReqB) begin
          state_d      = GNT_B;
          hold_cnt_d   = '0;
          last_owner_d = OWN_B;
          sel_d        = 1'b1;
        end
      end

      GNT_A: begin
        if (!bus.ReqA || (bus.ReqB && hold_expired)) begin
          if (bus.ReqB) begin
            state_d      = GNT_B;
            hold_cnt_d   = '0;
            last_owner_d = OWN_B;
            sel_d        = 1'b1;
            preempt_d    = bus.ReqA;  // A still wanted the bus: this is a forced switch
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_inc;
        end
      end

      GNT_B: begin
        if (!bus.ReqB || (bus.ReqA && hold_expired)) begin
          if (bus.ReqA) begin
            state_d      = GNT_A;
            hold_cnt_d   = '0;
            last_owner_d = OWN_A;
            sel_d        = 1'b0;
            preempt_d    = bus.ReqB;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_inc;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset leaves B as last owner so A wins the first tie.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      last_owner_q <= OWN_B;
      sel_q        <= 1'b0;
      preempt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
      sel_q        <= sel_d;
      preempt_q    <= preempt_d;
    end
  end

  assign bus.GrantA   = (state_q == GNT_A);
  assign bus.GrantB   = (state_q == GNT_B);
  assign bus.Selector = sel_q;
  assign bus.Busy     = (state_q == GNT_A) || (state_q == GNT_B);
  assign bus.Preempt  = preempt_q;

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Directed bench for bus_select_arbiter (MAX_HOLD = 8).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
// Observed vector layout: {GrantA, GrantB, Selector, Busy, Preempt}.
module tb_bus_select_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bus_select_arbiter_if bus ();

  bus_select_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] obs;
  assign obs = {bus.GrantA, bus.GrantB, bus.Selector, bus.Busy, bus.Preempt};

  localparam logic [4:0] V_IDLE0 = 5'b00000;
  localparam logic [4:0] V_IDLE1 = 5'b00100;
  localparam logic [4:0] V_A     = 5'b10010;
  localparam logic [4:0] V_A_PRE = 5'b10011;
  localparam logic [4:0] V_B     = 5'b01110;
  localparam logic [4:0] V_B_PRE = 5'b01111;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ReqA = 1'b1;
    bus.ReqB = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (obs !== V_IDLE0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, obs, V_IDLE0);
      end
    end
    rst = 1'b0;
    tick();
    total++;
    if (obs !== V_A) begin
      bad++;
      $display("FAIL reset_first_tie got=%b want=%b", obs, V_A);
    end
    bus.ReqA = 1'b0;
    bus.ReqB = 1'b0;
    tick();
    total++;
    if (obs !== V_IDLE0) begin
      bad++;
      $display("FAIL reset_release got=%b want=%b", obs, V_IDLE0);
    end
  endtask

  task automatic test_single();
    bus.ReqB = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++;
      if (obs !== V_B) begin
        bad++;
        $display("FAIL single_b cyc=%0d got=%b want=%b", i, obs, V_B);
      end
    end
    bus.ReqB = 1'b0;
    tick();
    total++;
    if (obs !== V_IDLE1) begin
      bad++;
      $display("FAIL single_release got=%b want=%b", obs, V_IDLE1);
    end
  endtask

  task automatic test_contention();
    logic [4:0] exp;
    logic       a_turn;
    logic       pre;
    // Idle with last owner B: A first, then alternate every 8 cycles.
    bus.ReqA = 1'b1;
    bus.ReqB = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tick();
      a_turn = ((c / 8) % 2) == 0;
      pre    = (c == 8) || (c == 16);
      exp    = a_turn ? {4'b1001, pre} : {4'b0111, pre};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL contention cyc=%0d got=%b want=%b", c, obs, exp);
      end
    end
    bus.ReqA = 1'b0;
    bus.ReqB = 1'b0;
    tick();
    total++;
    if (obs !== V_IDLE0) begin
      bad++;
      $display("FAIL contention_release got=%b want=%b", obs, V_IDLE0);
    end
  endtask

  task automatic test_back_to_back();
    // A alone, B joins, A releases after its 3rd grant cycle.
    bus.ReqA = 1'b1;
    tick();
    total++;
    if (obs !== V_A) begin
      bad++;
      $display("FAIL handover_a1 got=%b want=%b", obs, V_A);
    end
    bus.ReqB = 1'b1;
    for (int i = 2; i <= 3; i++) begin
      tick();
      total++;
      if (obs !== V_A) begin
        bad++;
        $display("FAIL handover_a%0d got=%b want=%b", i, obs, V_A);
      end
    end
    bus.ReqA = 1'b0;
    tick();
    total++;
    if (obs !== V_B) begin
      bad++;
      $display("FAIL handover_direct got=%b want=%b", obs, V_B);
    end
    // A returns: B must still get a full 8 cycles, proving the count restarted.
    bus.ReqA = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      tick();
      total++;
      if (obs !== V_B) begin
        bad++;
        $display("FAIL handover_bhold cyc=%0d got=%b want=%b", i, obs, V_B);
      end
    end
    tick();
    total++;
    if (obs !== V_A_PRE) begin
      bad++;
      $display("FAIL handover_preempt got=%b want=%b", obs, V_A_PRE);
    end
    bus.ReqA = 1'b0;
    bus.ReqB = 1'b0;
    tick();
  endtask

  task automatic test_rr_tie();
    bus.ReqB = 1'b1;
    tick();
    total++;
    if (obs !== V_B) begin
      bad++;
      $display("FAIL rr_b_grant got=%b want=%b", obs, V_B);
    end
    bus.ReqB = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (obs !== V_IDLE1) begin
        bad++;
        $display("FAIL rr_gap cyc=%0d got=%b want=%b", i, obs, V_IDLE1);
      end
    end
    bus.ReqA = 1'b1;
    bus.ReqB = 1'b1;
    tick();
    total++;
    if (obs !== V_A) begin
      bad++;
      $display("FAIL rr_tie got=%b want=%b", obs, V_A);
    end
    bus.ReqA = 1'b0;
    bus.ReqB = 1'b0;
    tick();
  endtask

  task automatic test_sat_preempt();
    // Long uncontended hold; B's arrival must preempt on the very next edge.
    bus.ReqA = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++;
      if (obs !== V_A) begin
        bad++;
        $display("FAIL sat_hold cyc=%0d got=%b want=%b", i, obs, V_A);
      end
    end
    bus.ReqB = 1'b1;
    tick();
    total++;
    if (obs !== V_B_PRE) begin
      bad++;
      $display("FAIL sat_preempt got=%b want=%b", obs, V_B_PRE);
    end
    tick();
    total++;
    if (obs !== V_B) begin
      bad++;
      $display("FAIL sat_pulse_width got=%b want=%b", obs, V_B);
    end
    bus.ReqA = 1'b0;
    bus.ReqB = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    // Last owner B, so the tie goes to A; reset on the edge where the count is 7.
    bus.ReqA = 1'b1;
    bus.ReqB = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (obs !== V_A) begin
        bad++;
        $display("FAIL rstmid_hold cyc=%0d got=%b want=%b", i, obs, V_A);
      end
    end
    rst = 1'b1;
    tick();
    total++;
    if (obs !== V_IDLE0) begin
      bad++;
      $display("FAIL rstmid_clear got=%b want=%b", obs, V_IDLE0);
    end
    rst = 1'b0;
    tick();
    total++;
    if (obs !== V_A) begin
      bad++;
      $display("FAIL rstmid_tie got=%b want=%b", obs, V_A);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    bus.ReqA = 1'b0;
    bus.ReqB = 1'b0;
    #1;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_rr_tie();
    test_sat_preempt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_select_arbiter.md
Name: bus_select_arbiter

Overview:
- Two-requester arbiter that owns the select line of the shared 16-bit 2:1 operand/address mux in the accumulator datapath.
- Requester A is the instruction-fetch path (mux input A, Selector=0). Requester B is the data-access path (mux input B, Selector=1).
- Grants are round-robin with a bounded hold time, so neither side can starve the other.
- The registered Selector drives the mux directly. The mux select never changes except on a grant hand-over.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles while the other side is requesting. Legal range 1..15; 0 = unlimited hold.
- CNT_W, 4, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- ReqA  input  1  request from fetch path; level, held while the bus is needed
- ReqB  input  1  request from data path; level, held while the bus is needed
- GrantA  output  1  registered; A owns the mux
- GrantB  output  1  registered; B owns the mux
- Selector  output  1  registered mux select; 0 = input A, 1 = input B
- Busy  output  1  GrantA | GrantB
- Preempt  output  1  one-cycle pulse on the cycle a forced hand-over takes effect

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous and active-high; it is sampled on the rising edge of CLK.
- Reset values:
  - State = IDLE.
  - GrantA = GrantB = 0; Selector = 0; Busy = 0; Preempt = 0.
  - hold_cnt = 0; last_owner = B, so A wins the first tie.
- Reset mid-grant: at the next edge the grant drops and all of the above apply, regardless of the Req inputs.
- States: IDLE, GNT_A, GNT_B. GrantA = (state==GNT_A); GrantB = (state==GNT_B). All outputs are registered.
- Latency: a request sampled high at edge N in IDLE gives a grant visible after edge N (one cycle).
- IDLE transitions:
  - ReqA & ReqB: grant the side that is not last_owner.
  - Only ReqA: go to GNT_A.
  - Only ReqB: go to GNT_B.
  - Neither: stay in IDLE.
- Entering any grant state: hold_cnt <= 0; last_owner <= new owner; Selector <= 0 for A, 1 for B.
- In IDLE, Selector holds its previous value so the mux does not toggle.
- GNT_A rules (GNT_B is symmetric):
  - ReqA low: go to GNT_B if ReqB is high (direct hand-over, no IDLE bubble), otherwise go to IDLE. Preempt = 0.
  - ReqA high, ReqB high, MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1: forced switch to GNT_B; Preempt = 1 for exactly the first GNT_B cycle.
  - Otherwise stay in GNT_A; hold_cnt increments, saturating at 2^CNT_W-1.
- Under contention the owner therefore holds the grant for exactly MAX_HOLD cycles.
- Without contention the hold is unlimited. hold_cnt keeps counting and saturates, but a saturated count does not trigger preemption until the other Req rises. Preemption then occurs at the next edge if hold_cnt >= MAX_HOLD-1.
- Both grants are never high in the same cycle. Selector always equals the current owner while Busy = 1.
- A requester dropping Req in the same cycle its grant arrives: the grant is held for that one cycle, then released per the rules above.
- Simultaneous release by the owner and request by the other side: direct hand-over, no idle cycle.
- Req inputs are assumed synchronous to CLK. The block adds no synchronizers.

Test Plan:
- Reset: assert Reset for 2 cycles with ReqA=ReqB=1 → GrantA=GrantB=Busy=Preempt=0 and Selector=0 throughout. After release, GrantA=1 at the first edge (tie goes to A).
- Single requester: ReqB=1 for 20 cycles, ReqA=0 → GrantB=1 and Selector=1 from cycle 1 through cycle 20, Preempt never asserts. ReqB low → GrantB=0 one edge later, Selector stays 1.
- Contention with MAX_HOLD=8: ReqA=ReqB=1 continuously from idle → ownership pattern A×8, B×8, A×8. Preempt pulses on the first cycle of each switch. Selector toggles only on those edges.
- Voluntary hand-over: A granted; ReqB rises; ReqA drops after 3 grant cycles → GrantB=1 on the very next edge with no IDLE gap. Preempt=0, hold_cnt restarts at 0.
- Round-robin tie after an idle gap: B granted, both Reqs drop for 2 cycles, then both rise in the same cycle → A granted.
- Reset mid-preemption: apply Reset on the edge where hold_cnt == 7 under contention → all outputs 0 next cycle, Selector=0. The first post-reset tie grants A.
